showdown_scheduler: RTL

Sequences the showdown at the end of a hand by time-multiplexing one shared combinational flush evaluator across all seated players. On `start` it snapshots every player's two hole cards, the five community cards and the active (not folded) mask. It presents each active player's seven cards to the evaluator in turn and keeps the best `{flush, high card}` score. It sits between the game-flow FSM, which pulses `start` and consumes `done`/`winner`, and the single shared evaluator instance.

---
 rtl/poker_pkg.sv | 26 ++
 rtl/hand_score_cmp.sv | 12 +
 rtl/showdown_scheduler.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/poker_pkg.sv
// poker_pkg: card format, score width and showdown FSM states shared by poker blocks
package poker_pkg;
  localparam int CARD_W   = 6;
  localparam int NUM_W    = 4;
  localparam int FLOWER_W = 2;
  localparam int SCORE_W  = 5;
  localparam int HOLE_W   = 2 * CARD_W;
  localparam int COMM_W   = 5 * CARD_W;
  localparam logic [NUM_W-1:0] ACE_NUM  = 4'd0;
  localparam logic [NUM_W-1:0] ACE_RANK = 4'd13;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} showdown_state_t;

  function automatic logic [NUM_W-1:0] card_num(input logic [CARD_W-1:0] c);
    return c[CARD_W-1:FLOWER_W];
  endfunction

  function automatic logic [FLOWER_W-1:0] card_flower(input logic [CARD_W-1:0] c);
    return c[FLOWER_W-1:0];
  endfunction

  // Ace is stored as 0 but outranks the King, so it is promoted for comparisons
  function automatic logic [NUM_W-1:0] card_rank(input logic [CARD_W-1:0] c);
    return (card_num(c) == ACE_NUM) ? ACE_RANK : card_num(c);
  endfunction
endpackage

// File: rtl/hand_score_cmp.sv
// hand_score_cmp: unsigned compare of a candidate score against the running best
module hand_score_cmp
  import poker_pkg::*;
(
  input  logic [SCORE_W-1:0] score,
  input  logic [SCORE_W-1:0] best,
  output logic               gt,
  output logic               eq
);
  assign gt = score > best;
  assign eq = score == best;
endmodule

// File: rtl/showdown_scheduler.sv
// showdown_scheduler: walks active seats through one shared flush evaluator and
// reports the best {flush, high card} score, its lowest-indexed holder and ties.
module showdown_scheduler
  import poker_pkg::*;
#(
  parameter int NUM_PLAYERS = 4,
  parameter int IDX_W       = $clog2(NUM_PLAYERS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [HOLE_W*NUM_PLAYERS-1:0] hole_cards,
  input  logic [COMM_W-1:0]            community_cards,
  input  logic [NUM_PLAYERS-1:0]       active,
  output logic [HOLE_W-1:0]            eval_hole_cards,
  output logic [COMM_W-1:0]            eval_community_cards,
  input  logic                         eval_is_flush,
  input  logic [NUM_W-1:0]             eval_flush_max_num,
  output logic                         busy,
  output logic                         done,
  output logic [IDX_W-1:0]             winner,
  output logic                         winner_valid,
  output logic                         tie,
  output logic                         best_is_flush,
  output logic [NUM_W-1:0]             best_max_num
);
  showdown_state_t                     state_q, state_d;
  logic [IDX_W-1:0]                    ptr_q, ptr_d, win_q, win_d, winner_q, winner_d;
  logic [NUM_PLAYERS-1:0][HOLE_W-1:0]  snap_hole_q, snap_hole_d;
  logic [COMM_W-1:0]                   snap_comm_q, snap_comm_d, eval_comm_q, eval_comm_d;
  logic [NUM_PLAYERS-1:0]              snap_act_q, snap_act_d;
  logic [HOLE_W-1:0]                   eval_hole_q, eval_hole_d;
  logic [SCORE_W-1:0]                  best_q, best_d, score, res_best_q, res_best_d;
  logic                                tie_q, tie_d, found_q, found_d;
  logic                                res_tie_q, res_tie_d, res_valid_q, res_valid_d;
  logic                                gt, eq, last;

  assign score = eval_is_flush ? {1'b1, eval_flush_max_num} : '0;
  assign last  = ptr_q == IDX_W'(NUM_PLAYERS - 1);

  hand_score_cmp u_cmp (
    .score(score),
    .best (best_q),
    .gt   (gt),
    .eq   (eq)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    snap_hole_d = snap_hole_q;
    snap_comm_d = snap_comm_q;
    snap_act_d  = snap_act_q;
    eval_hole_d = eval_hole_q;
    eval_comm_d = eval_comm_q;
    best_d      = best_q;
    win_d       = win_q;
    tie_d       = tie_q;
    found_d     = found_q;
    case (state_q)
      IDLE: if (start) begin
        snap_hole_d = hole_cards;
        snap_comm_d = community_cards;
        snap_act_d  = active;
        ptr_d       = '0;
        best_d      = '0;
        win_d       = '0;
        tie_d       = 1'b0;
        found_d     = 1'b0;
        state_d     = DRIVE;
      end
      DRIVE: if (snap_act_q[ptr_q]) begin
        eval_hole_d = snap_hole_q[ptr_q];
        eval_comm_d = snap_comm_q;
        state_d     = SAMPLE;
      end else begin
        state_d = last ? DONE : DRIVE;
        ptr_d   = last ? ptr_q : ptr_q + 1'b1;
      end
      SAMPLE: begin
        if (!found_q || gt) begin
          best_d = score;
          win_d  = ptr_q;
          tie_d  = 1'b0;
        end else if (eq) begin
          tie_d = 1'b1;
        end
        found_d = 1'b1;
        state_d = last ? DONE : DRIVE;
        ptr_d   = last ? ptr_q : ptr_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // results are captured from the post-update running values on the edge entering DONE
  always_comb begin
    winner_d    = winner_q;
    res_best_d  = res_best_q;
    res_tie_d   = res_tie_q;
    res_valid_d = res_valid_q;
    if (state_d == DONE && state_q != DONE) begin
      winner_d    = win_d;
      res_best_d  = best_d;
      res_tie_d   = tie_d;
      res_valid_d = found_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      snap_hole_q <= '0;
      snap_comm_q <= '0;
      snap_act_q  <= '0;
      eval_hole_q <= '0;
      eval_comm_q <= '0;
      best_q      <= '0;
      win_q       <= '0;
      tie_q       <= 1'b0;
      found_q     <= 1'b0;
      winner_q    <= '0;
      res_best_q  <= '0;
      res_tie_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      snap_hole_q <= snap_hole_d;
      snap_comm_q <= snap_comm_d;
      snap_act_q  <= snap_act_d;
      eval_hole_q <= eval_hole_d;
      eval_comm_q <= eval_comm_d;
      best_q      <= best_d;
      win_q       <= win_d;
      tie_q       <= tie_d;
      found_q     <= found_d;
      winner_q    <= winner_d;
      res_best_q  <= res_best_d;
      res_tie_q   <= res_tie_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign busy                 = state_q != IDLE;
  assign done                 = state_q == DONE;
  assign winner               = winner_q;
  assign winner_valid         = res_valid_q;
  assign tie                  = res_tie_q;
  assign best_is_flush        = res_best_q[SCORE_W-1];
  assign best_max_num         = res_best_q[NUM_W-1:0];
  assign eval_hole_cards      = eval_hole_q;
  assign eval_community_cards = eval_comm_q;
endmodule
